tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one serial TX frame transmitter between N requesters.
- Each requester offers a BIT_LEN-bit word with a valid/ready handshake.
- The arbiter picks one requester, latches its word, pulses the transmitter start, then holds off for a fixed frame time before the next grant.
- Sits between the per-channel producers and the single TX instance driving the shared channel line.

---
 rtl/tx_arbiter_pkg.sv | 20 ++
 rtl/tx_arbiter_rr_pick.sv | 36 +++
 rtl/tx_arbiter.sv | 111 +++++++++++
 tb/tb_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the TX frame arbiter and the serial TX it feeds.
// Holds the arbiter state encoding and the frame-length derivation, so the
// arbiter hold-off and the TX frame format are computed from the same place.
package tx_arbiter_pkg;

    // Two-bit state encoding; the fourth code is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Start bit + data bits + parity + stop + one turnaround cycle.
    localparam int FRAME_OVERHEAD = 4;

    function automatic int frame_cycles(input int bit_len);
        return bit_len + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin picker: finds the first set bit in 'valid', scanning from the
// position after 'last' and wrapping modulo N. Purely combinational.
// Ports:
//   valid  in  N         request vector
//   last   in  IDX_W     index granted most recently (lowest priority now)
//   grant  out N         one-hot winner, all zero when nothing is valid
//   idx    out IDX_W     encoded winner index
//   any    out 1         at least one request is valid
module tx_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one serial TX frame transmitter between N
// requesters. One word is accepted per frame; after the start pulse the
// arbiter holds off for the full frame time before granting again.
// Ports:
//   clk        in  1           system clock, rising edge
//   rstn       in  1           asynchronous active-low reset
//   req_valid  in  N           per-requester word available
//   req_data   in  N*BIT_LEN   packed words, requester i at [i*BIT_LEN +: BIT_LEN]
//   req_ready  out N           one-hot accept, only in IDLE
//   tx_start   out 1           one-cycle start pulse to the TX
//   tx_data    out BIT_LEN     word presented to the TX, held until next accept
//   busy       out 1           accept cycle through end of frame window
//   grant_id   out IDX_W       requester granted most recently
//
// state    | meaning
// ST_IDLE  | waiting for any req_valid; accept happens combinationally here
// ST_ISSUE | tx_start high for this single cycle
// ST_WAIT  | frame in flight, counting FRAME_CYCLES cycles
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int N            = 4,
    parameter int BIT_LEN      = 7,
    parameter int FRAME_CYCLES = frame_cycles(BIT_LEN),
    parameter int IDX_W        = $clog2(N),
    parameter int CNT_W        = $clog2(FRAME_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req_valid,
    input  logic [N*BIT_LEN-1:0] req_data,
    output logic [N-1:0]         req_ready,
    output logic                 tx_start,
    output logic [BIT_LEN-1:0]   tx_data,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_id
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;

    logic [N-1:0]     pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    tx_arbiter_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The accept is combinational, so it is qualified with rstn to keep
    // req_ready low while reset is held even though the state is IDLE.
    assign req_ready = (rstn && state == ST_IDLE) ? pick_grant : '0;

    // busy covers the accept cycle itself, before the registered flag rises.
    assign busy = busy_r | (|req_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy_r   <= 1'b0;
            grant_id <= '0;
            last     <= IDX_W'(N - 1);
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        tx_data  <= req_data[pick_idx*BIT_LEN +: BIT_LEN];
                        grant_id <= pick_idx;
                        last     <= pick_idx;
                        busy_r   <= 1'b1;
                        tx_start <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tx_start <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter at default parameters (N=4, BIT_LEN=7,
// FRAME_CYCLES=11). Inputs change on the falling edge; outputs are sampled
// on the falling edge (registered) or 1ns after it (combinational).
module tb_tx_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [27:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [6:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tx_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic apply_reset();
        req_valid = '0;
        req_data  = '0;
        rstn      = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Waits (bounded) for a tx_start pulse, records it, then steps one cycle past it.
    task automatic wait_start(output logic found, output int t,
                              output logic [1:0] g, output logic [6:0] d);
        found = 1'b0; t = 0; g = '0; d = '0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (tx_start) begin
                found = 1'b1; t = cyc; g = grant_id; d = tx_data;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = '0; req_data = '0;
        @(negedge clk);
        checks++;
        if ({req_ready, tx_start, tx_data, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b st=%b data=%h busy=%b gid=%0d required all 0",
                     req_ready, tx_start, tx_data, busy, grant_id);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_gated: got rdy=%b busy=%b required 0000 0", req_ready, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int busy_cnt;
        int starts;
        int guard;
        apply_reset();
        req_data[14 +: 7] = 7'h55;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got rdy=%b busy=%b required 0100 1", req_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_data !== 7'h55 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_issue: got st=%b gid=%0d data=%h rdy=%b required 1 2 55 0000",
                     tx_start, grant_id, tx_data, req_ready);
        end
        req_valid = '0;
        busy_cnt = 1; starts = 0; guard = 0;
        while (busy && guard < 40) begin
            busy_cnt++;
            if (tx_start) starts++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt !== 13) begin
            errors++;
            $display("FAIL single_busy_len: got %0d required 13", busy_cnt);
        end
        checks++;
        if (starts !== 1 || tx_data !== 7'h55) begin
            errors++;
            $display("FAIL single_pulse_hold: got starts=%0d data=%h required 1 55", starts, tx_data);
        end
    endtask

    task automatic test_two();
        logic       found;
        int         t, t_prev;
        logic [1:0] g;
        logic [6:0] d;
        logic [1:0] exp_g [4];
        logic [6:0] exp_d [4];
        exp_g = '{2'd0, 2'd3, 2'd0, 2'd3};
        exp_d = '{7'h11, 7'h33, 7'h11, 7'h33};
        apply_reset();
        req_data  = {7'h33, 7'h00, 7'h00, 7'h11};
        req_valid = 4'b1001;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_start(found, t, g, d);
            checks++;
            if (!found || g !== exp_g[i] || d !== exp_d[i]) begin
                errors++;
                $display("FAIL two_grant%0d: got found=%b gid=%0d data=%h required 1 %0d %h",
                         i, found, g, d, exp_g[i], exp_d[i]);
            end
            if (i > 0) begin
                checks++;
                if (t - t_prev !== 13) begin
                    errors++;
                    $display("FAIL two_spacing%0d: got %0d cycles required 13", i, t - t_prev);
                end
            end
            t_prev = t;
        end
    endtask

    task automatic test_all_four();
        logic       found;
        int         t;
        logic [1:0] g;
        logic [6:0] d;
        logic [6:0] exp_d [5];
        logic [1:0] exp_g [5];
        exp_d = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h01};
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        req_data  = {7'h04, 7'h03, 7'h02, 7'h01};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(found, t, g, d);
            checks++;
            if (!found || d !== exp_d[i] || g !== exp_g[i]) begin
                errors++;
                $display("FAIL all4_grant%0d: got found=%b gid=%0d data=%h required 1 %0d %h",
                         i, found, g, d, exp_g[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_withdrawn();
        logic r1_seen;
        int   guard;
        apply_reset();
        req_data  = {7'h00, 7'h2C, 7'h1B, 7'h0A};
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wd_first_accept: got rdy=%b required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0110;
        r1_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_ready[1]) r1_seen = 1'b1;
            @(negedge clk);
        end
        req_valid = 4'b0100;
        guard = 0;
        #1;
        while (req_ready === 4'b0000 && guard < 30) begin
            guard++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (req_ready !== 4'b0100 || r1_seen) begin
            errors++;
            $display("FAIL wd_next_accept: got rdy=%b r1_seen=%b required 0100 0", req_ready, r1_seen);
        end
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd2 || tx_data !== 7'h2C) begin
            errors++;
            $display("FAIL wd_next_grant: got gid=%0d data=%h required 2 2c", grant_id, tx_data);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic       found;
        int         t;
        logic [1:0] g;
        logic [6:0] d;
        apply_reset();
        req_data  = {7'h04, 7'h03, 7'h02, 7'h01};
        req_valid = 4'b1111;
        wait_start(found, t, g, d);
        wait_start(found, t, g, d);
        checks++;
        if (!found || g !== 2'd1) begin
            errors++;
            $display("FAIL rmid_pre_grant: got found=%b gid=%0d required 1 1", found, g);
        end
        repeat (4) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({req_ready, tx_start, tx_data, busy, grant_id} !== '0) begin
            errors++;
            $display("FAIL rmid_async_clear: got rdy=%b st=%b data=%h busy=%b gid=%0d required all 0",
                     req_ready, tx_start, tx_data, busy, grant_id);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_first_accept: got rdy=%b required 0001", req_ready);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 7'h01) begin
            errors++;
            $display("FAIL rmid_first_grant: got st=%b gid=%0d data=%h required 1 0 01",
                     tx_start, grant_id, tx_data);
        end
    endtask

    task automatic test_idle();
        int guard;
        req_valid = '0;
        guard = 0;
        while (busy && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_drain: got busy=%b required 0", busy);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (tx_start !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || tx_data !== 7'h01) begin
                errors++;
                $display("FAIL idle_cycle%0d: got st=%b busy=%b rdy=%b data=%h required 0 0 0000 01",
                         i, tx_start, busy, req_ready, tx_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_all_four();
        test_withdrawn();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
